// File: rtl/box_nest_solver.sv
`default_nettype none
// ============================================================================
//  Module   : box_nest_solver
//  Purpose  : Accepts a set of boxes (width, height) as a valid/ready beat
//             stream. It then finds the longest chain of strictly nested boxes
//             by sweeping the stored boxes repeatedly (Bellman-Ford style)
//             until a sweep makes no change.
//  Revision : 1.0  initial release
//  Config   : BOX_ROTATE_EN  - when defined, each box is stored normalised
//                              (w = max, h = min), so boxes may be rotated.
//  Ports    : clk, rst (async, active-low), clear (sync abort)
//             in_valid/in_ready/in_w/in_h/in_last : box beat stream
//             busy, done, count, answer, overflow : status / result
//             hled0..hled5 : active-low 7-segment hex digits of answer
// ============================================================================
module box_nest_solver #(
  parameter int N  = 100,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_w,
  input  logic [DW-1:0] in_h,
  input  logic          in_last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic [CW-1:0] answer,
  output logic          overflow,
  output logic [6:0]    hled0,
  output logic [6:0]    hled1,
  output logic [6:0]    hled2,
  output logic [6:0]    hled3,
  output logic [6:0]    hled4,
  output logic [6:0]    hled5
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SOLVE = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_answer;
  logic          r_overflow;
  logic [CW-1:0] r_j;
  logic          r_chg;      // some n[] changed earlier in the current sweep
  logic [DW-1:0] r_w [N];
  logic [DW-1:0] r_h [N];
  logic [CW-1:0] r_n [N];

  // Incoming beat handling
  logic          w_xfer;
  logic          w_start;
  logic          w_store;
  logic          w_full;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] w_sw;
  logic [DW-1:0] w_sh;

  assign w_xfer      = in_valid && in_ready;
  assign w_start     = w_xfer && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_base      = w_start ? '0 : r_count;
  assign w_store     = w_xfer && (in_w != '0) && (in_h != '0);
  assign w_count_nxt = w_base + {{(CW-1){1'b0}}, w_store};
  assign w_full      = w_store && (w_count_nxt == CW'(N));

`ifdef BOX_ROTATE_EN
  assign w_sw = (in_w > in_h) ? in_w : in_h;
  assign w_sh = (in_w > in_h) ? in_h : in_w;
`else
  assign w_sw = in_w;
  assign w_sh = in_h;
`endif

  // Solve datapath: select box j, then find every box i that can improve
  // its chain length by wrapping box j.
  logic [DW-1:0] w_wj;
  logic [DW-1:0] w_hj;
  logic [CW-1:0] w_nj;
  logic [CW-1:0] w_nj1;
  logic [N-1:0]  w_upd;
  logic          w_chg;
  logic          w_last_j;
  logic [CW-1:0] w_ans_nxt;

  always_comb begin
    w_wj = '0;
    w_hj = '0;
    w_nj = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) == r_j) begin
        w_wj = r_w[i];
        w_hj = r_h[i];
        w_nj = r_n[i];
      end
    end
  end

  assign w_nj1 = w_nj + CW'(1);

  always_comb begin
    w_upd = '0;
    for (int i = 0; i < N; i++) begin
      w_upd[i] = (CW'(i) < r_count) && (r_w[i] > w_wj) && (r_h[i] > w_hj)
                 && (r_n[i] < w_nj1);
    end
  end

  assign w_chg     = |w_upd;
  assign w_last_j  = (r_j == (r_count - CW'(1)));
  assign w_ans_nxt = (w_nj > r_answer) ? w_nj : r_answer;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE, c_LOAD, c_DONE: begin
          if (w_xfer) w_state_nxt = (in_last || w_full) ? c_SOLVE : c_LOAD;
        end
        c_SOLVE: begin
          if (r_count == '0)  w_state_nxt = c_DONE;
          else if (w_last_j)  w_state_nxt = (r_chg || w_chg) ? c_SOLVE : c_DONE;
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      c_LOAD:  busy = 1'b1;
      c_SOLVE: begin busy = 1'b1; in_ready = 1'b0; end
      c_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_answer   <= '0;
      r_overflow <= 1'b0;
      r_j        <= '0;
      r_chg      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_w[i] <= '0;
        r_h[i] <= '0;
        r_n[i] <= CW'(1);
      end
    end else if (clear) begin
      r_count    <= '0;
      r_answer   <= '0;
      r_overflow <= 1'b0;
      r_j        <= '0;
      r_chg      <= 1'b0;
    end else if (w_xfer) begin
      if (w_start) begin
        r_answer   <= '0;
        r_overflow <= 1'b0;
        for (int i = 0; i < N; i++) r_n[i] <= CW'(1);
      end
      if (w_store) begin
        for (int i = 0; i < N; i++) begin
          if (CW'(i) == w_base) begin
            r_w[i] <= w_sw;
            r_h[i] <= w_sh;
          end
        end
      end
      // Overflow only when the set is cut short; a full set ending on
      // in_last is complete.
      if (w_full && !in_last) r_overflow <= 1'b1;
      r_count <= w_count_nxt;
      r_j     <= '0;
      r_chg   <= 1'b0;
    end else if ((r_state == c_SOLVE) && (r_count != '0)) begin
      for (int i = 0; i < N; i++) begin
        if (w_upd[i]) r_n[i] <= w_nj1;
      end
      r_answer <= w_ans_nxt;
      if (w_last_j) begin
        r_j   <= '0;
        r_chg <= 1'b0;
      end else begin
        r_j   <= r_j + CW'(1);
        r_chg <= r_chg | w_chg;
      end
    end
  end

  assign count    = r_count;
  assign answer   = r_answer;
  assign overflow = r_overflow;

  // Hex display (active-low segments, gfedcba)
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [23:0] w_ans24;
  assign w_ans24 = 24'(r_answer);
  assign hled0 = seg7(w_ans24[3:0]);
  assign hled1 = seg7(w_ans24[7:4]);
  assign hled2 = seg7(w_ans24[11:8]);
  assign hled3 = seg7(w_ans24[15:12]);
  assign hled4 = seg7(w_ans24[19:16]);
  assign hled5 = seg7(w_ans24[23:20]);

endmodule
`default_nettype wire

// File: tb/tb_box_nest_solver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_box_nest_solver
//  Purpose  : Self-checking bench for box_nest_solver (N=4, DW=16, CW=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_box_nest_solver;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [6:0] c_SEG0 = 7'b1000000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_w = '0;
  logic [DW-1:0] in_h = '0;
  logic          in_last = 1'b0;
  logic          busy, done, overflow;
  logic [CW-1:0] count, answer;
  logic [6:0]    hled0, hled1, hled2, hled3, hled4, hled5;

  int n_pass = 0;
  int n_total = 0;

  box_nest_solver #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_h(in_h),
    .in_last(in_last), .busy(busy), .done(done), .count(count),
    .answer(answer), .overflow(overflow),
    .hled0(hled0), .hled1(hled1), .hled2(hled2),
    .hled3(hled3), .hled4(hled4), .hled5(hled5)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              nb;
    logic [3:0][15:0] w;
    logic [3:0][15:0] h;
    int              cnt;
    int              ans;
    logic [6:0]      hl;
  } vec_t;

  vec_t vecs[8];
  int   n_vecs = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int nb,
                     input int w0, input int h0, input int w1, input int h1,
                     input int w2, input int h2, input int w3, input int h3,
                     input int cnt, input int ans, input logic [6:0] hl);
    vecs[n_vecs].nb  = nb;
    vecs[n_vecs].w[0] = 16'(w0); vecs[n_vecs].h[0] = 16'(h0);
    vecs[n_vecs].w[1] = 16'(w1); vecs[n_vecs].h[1] = 16'(h1);
    vecs[n_vecs].w[2] = 16'(w2); vecs[n_vecs].h[2] = 16'(h2);
    vecs[n_vecs].w[3] = 16'(w3); vecs[n_vecs].h[3] = 16'(h3);
    vecs[n_vecs].cnt = cnt;
    vecs[n_vecs].ans = ans;
    vecs[n_vecs].hl  = hl;
    n_vecs++;
  endtask

  // Drive one beat at the falling edge; it transfers on the next rising edge.
  task automatic send_beat(input int w, input int h, input logic last);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    in_w     = 16'(w);
    in_h     = 16'(h);
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, int'(done), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, int'(in_ready), 1);
    check({name, "_busy"},     int'(busy), 0);
    check({name, "_done"},     int'(done), 0);
    check({name, "_count"},    int'(count), 0);
    check({name, "_answer"},   int'(answer), 0);
    check({name, "_overflow"}, int'(overflow), 0);
    check({name, "_hled0"},    int'(hled0), int'(c_SEG0));
    check({name, "_hled5"},    int'(hled5), int'(c_SEG0));
  endtask

  initial begin
    // Table of complete sets: beats, expected count, answer, hled0
    add(3, 1,1, 2,2, 3,3, 0,0, 3, 3, 7'b0110000);
`ifdef BOX_ROTATE_EN
    add(2, 1,4, 5,2, 0,0, 0,0, 2, 2, 7'b0100100);
`else
    add(2, 1,4, 5,2, 0,0, 0,0, 2, 1, 7'b1111001);
`endif
    add(4, 2,2, 2,2, 0,3, 1,1, 3, 2, 7'b0100100);
    add(2, 3,1, 1,3, 0,0, 0,0, 2, 1, 7'b1111001);
    add(1, 0,5, 0,0, 0,0, 0,0, 0, 0, 7'b1000000);
    add(4, 5,5, 4,4, 3,3, 2,2, 4, 4, 7'b0011001);
    add(3, 2,5, 3,6, 1,7, 0,0, 3, 2, 7'b0100100);

    // Reset state, checked while rst is still asserted
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Overflow: four boxes without in_last, a fifth presented while solving
    send_beat(1, 1, 1'b0);
    send_beat(2, 2, 1'b0);
    send_beat(3, 3, 1'b0);
    send_beat(4, 4, 1'b0);
    check("ovf_in_ready", int'(in_ready), 0);
    check("ovf_busy", int'(busy), 1);
    in_valid = 1'b1; in_w = 16'd9; in_h = 16'd9;
    @(negedge clk);
    check("ovf_fifth_not_taken", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_done("ovf");
    check("ovf_flag", int'(overflow), 1);
    check("ovf_count", int'(count), 4);
    check("ovf_answer", int'(answer), 4);

    // Table-driven sets, each started from DONE (new set clears state)
    for (int v = 0; v < n_vecs; v++) begin
      for (int b = 0; b < vecs[v].nb; b++)
        send_beat(int'(vecs[v].w[b]), int'(vecs[v].h[b]), b == vecs[v].nb - 1);
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), int'(count), vecs[v].cnt);
      check($sformatf("vec%0d_answer", v), int'(answer), vecs[v].ans);
      check($sformatf("vec%0d_overflow", v), int'(overflow), 0);
      check($sformatf("vec%0d_hled0", v), int'(hled0), int'(vecs[v].hl));
      check($sformatf("vec%0d_hled1", v), int'(hled1), int'(c_SEG0));
    end

    // Results hold in DONE while idle
    repeat (3) @(negedge clk);
    check("hold_done", int'(done), 1);
    check("hold_answer", int'(answer), vecs[n_vecs-1].ans);

    // Clear pulse mid-SOLVE
    send_beat(5, 5, 1'b0);
    send_beat(4, 4, 1'b0);
    send_beat(3, 3, 1'b0);
    send_beat(2, 2, 1'b1);
    @(negedge clk);
    check("clr_pre_busy", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", int'(busy), 0);
    check("clr_done", int'(done), 0);
    check("clr_answer", int'(answer), 0);
    check("clr_count", int'(count), 0);
    check("clr_in_ready", int'(in_ready), 1);
    send_beat(1, 1, 1'b0);
    send_beat(2, 3, 1'b1);
    wait_done("after_clr");
    check("after_clr_answer", int'(answer), 2);
    check("after_clr_count", int'(count), 2);

    // Asynchronous reset mid-LOAD
    send_beat(7, 7, 1'b0);
    send_beat(8, 8, 1'b0);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_count", int'(count), 2);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    send_beat(1, 2, 1'b0);
    send_beat(2, 3, 1'b0);
    send_beat(3, 4, 1'b1);
    wait_done("after_rst");
    check("after_rst_answer", int'(answer), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
